// File: rtl/usb_tx_pkg.sv
// Shared definitions for the USB transmit serializer.
//   tx_state_t        : packet-level transmit state
//   SYNC_BYTE         : SYNC pattern, sent LSB-first (seven 0s then a 1)
//   EOP_BITS          : number of SE0 bit periods closing each packet
//   DEF_CLKS_PER_BIT  : default clocks per USB bit period
//   DEF_STUFF_LIMIT   : default run of 1s that forces a stuffed 0
package usb_tx_pkg;

  localparam logic [7:0]  SYNC_BYTE        = 8'h80;
  localparam int unsigned EOP_BITS         = 2;
  localparam int unsigned DEF_CLKS_PER_BIT = 8;
  localparam int unsigned DEF_STUFF_LIMIT  = 6;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DATA,
    STUFF,
    EOP,
    IDLE_J
  } tx_state_t;

endpackage

// File: rtl/tx_bit_timer.sv
// Bit-period timer for the USB transmit serializer.
//   clk, rst : system clock, asynchronous active-high reset
//   run      : timer counts while high, held at 0 while low
//   tick     : one-cycle strobe on the last clock of each bit period
module tx_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = usb_tx_pkg::DEF_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tick
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  assign tick = run && (count == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (!run || tick) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/usb_tx_bit_stuffer.sv
// USB TX packet serializer with bit stuffing, feeding the NRZI encoder.
// Prepends SYNC, shifts packet bytes LSB-first at one bit per CLKS_PER_BIT
// clocks, inserts a 0 after STUFF_LIMIT consecutive 1s, and closes each
// packet with EOP_BITS SE0 periods followed by one J period.
//   clk, rst          : system clock, asynchronous active-high reset
//   tx_data, tx_last  : packet byte and final-byte flag
//   tx_data_valid     : byte available / packet start request
//   tx_data_ready     : one-cycle pulse, byte captured this cycle
//   serial_out        : current pre-NRZI bit (registered)
//   encoder_enable    : SYNC/DATA/STUFF/IDLE_J bit presented (registered)
//   clock_timer       : strobe on the last clock of each bit period
//   eop_enable        : SE0 periods (registered)
//   tx_busy           : not IDLE
//   tx_done           : pulse on exit from IDLE_J
//   tx_error          : pulse on underrun
module usb_tx_bit_stuffer
  import usb_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int unsigned STUFF_LIMIT  = DEF_STUFF_LIMIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  input  logic       tx_data_valid,
  output logic       tx_data_ready,
  output logic       serial_out,
  output logic       encoder_enable,
  output logic       clock_timer,
  output logic       eop_enable,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int unsigned SW = $clog2(STUFF_LIMIT + 1);
  localparam logic [SW-1:0] STUFF_MAX = SW'(STUFF_LIMIT);
  localparam logic [2:0]    EOP_LAST  = 3'(EOP_BITS - 1);

  tx_state_t     state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    byte_q;
  logic [7:0]    byte_nxt;
  logic          last_q;
  logic          pkt_end_q, pkt_end_d;
  logic [SW-1:0] ones_q, ones_d;

  logic          run;
  logic          tick;
  logic          start;
  logic          bit_load;
  logic          load;
  logic          stuff_due;
  logic          ready_c, err_c, done_c;
  logic          ser_d, enc_d, eop_d;

  assign run       = (state_q != IDLE);
  assign start     = (state_q == IDLE) && tx_data_valid;
  assign bit_load  = start || tick;
  // ones_q already counts the bit currently on the line.
  assign stuff_due = (ones_q == STUFF_MAX);
  assign byte_nxt  = load ? tx_data : byte_q;

  tx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk (clk),
    .rst (rst),
    .run (run),
    .tick(tick)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath decisions. idx_q is the bit on the line in
  // SYNC/DATA, the next data bit to send while in STUFF, and the SE0 period
  // count in EOP.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pkt_end_d = pkt_end_q;
    load      = 1'b0;
    ready_c   = 1'b0;
    err_c     = 1'b0;
    done_c    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (tx_data_valid) begin
          state_d   = SYNC;
          idx_d     = '0;
          pkt_end_d = 1'b0;
        end
      end
      SYNC: begin
        if (tick) begin
          if (idx_q == 3'd7) begin
            idx_d = '0;
            if (tx_data_valid) begin
              ready_c = 1'b1;
              load    = 1'b1;
              state_d = DATA;
            end else begin
              err_c   = 1'b1;
              state_d = EOP;
            end
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (idx_q == 3'd7 && !last_q && !tx_data_valid) begin
            // Underrun wins over a pending stuff bit.
            err_c   = 1'b1;
            state_d = EOP;
            idx_d   = '0;
          end else if (idx_q == 3'd7) begin
            idx_d = '0;
            if (last_q) begin
              pkt_end_d = 1'b1;
              state_d   = stuff_due ? STUFF : EOP;
            end else begin
              // Next byte is fetched at the bit-7 boundary even when a
              // stuff bit goes out first.
              ready_c = 1'b1;
              load    = 1'b1;
              state_d = stuff_due ? STUFF : DATA;
            end
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = stuff_due ? STUFF : DATA;
          end
        end
      end
      STUFF: begin
        if (tick) begin
          state_d = pkt_end_q ? EOP : DATA;
        end
      end
      EOP: begin
        if (tick) begin
          if (idx_q == EOP_LAST) begin
            idx_d   = '0;
            state_d = IDLE_J;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      IDLE_J: begin
        if (tick) begin
          state_d = IDLE;
          done_c  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode: line values for the bit that starts after this edge, plus
  // the per-cycle strobes.
  always_comb begin
    ser_d  = 1'b1;
    enc_d  = 1'b0;
    eop_d  = 1'b0;
    ones_d = ones_q;
    case (state_d)
      SYNC: begin
        ser_d = SYNC_BYTE[idx_d];
        enc_d = 1'b1;
      end
      DATA: begin
        ser_d = byte_nxt[idx_d];
        enc_d = 1'b1;
      end
      STUFF: begin
        ser_d = 1'b0;
        enc_d = 1'b1;
      end
      EOP: begin
        ser_d = 1'b0;
        eop_d = 1'b1;
      end
      IDLE_J: begin
        ser_d = 1'b1;
        enc_d = 1'b1;
      end
      default: begin
        ser_d = 1'b1;
      end
    endcase

    if (start) begin
      ones_d = '0;
    end else if (bit_load) begin
      if ((state_d == SYNC || state_d == DATA) && ser_d) begin
        ones_d = stuff_due ? ones_q : ones_q + SW'(1);
      end else begin
        ones_d = '0;
      end
    end
  end

  assign tx_data_ready = ready_c;
  assign tx_error      = err_c;
  assign tx_done       = done_c;
  assign clock_timer   = tick;
  assign tx_busy       = run;

  // Datapath and registered line outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q          <= '0;
      byte_q         <= '0;
      last_q         <= 1'b0;
      pkt_end_q      <= 1'b0;
      ones_q         <= '0;
      serial_out     <= 1'b1;
      encoder_enable <= 1'b0;
      eop_enable     <= 1'b0;
    end else begin
      idx_q          <= idx_d;
      pkt_end_q      <= pkt_end_d;
      ones_q         <= ones_d;
      serial_out     <= ser_d;
      encoder_enable <= enc_d;
      eop_enable     <= eop_d;
      if (load) begin
        byte_q <= tx_data;
        last_q <= tx_last;
      end
    end
  end

endmodule

// File: tb/tb_usb_tx_bit_stuffer.sv
// Self-checking bench for usb_tx_bit_stuffer: a stream-level model expands
// each packet into its bit periods and every cycle is compared against it.
module tb_usb_tx_bit_stuffer;

  localparam int unsigned CPB = 8;
  localparam int unsigned LIM = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_last;
  logic       tx_data_valid;
  logic       tx_data_ready;
  logic       serial_out;
  logic       encoder_enable;
  logic       clock_timer;
  logic       eop_enable;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_error;

  always #5 clk = ~clk;

  usb_tx_bit_stuffer #(
    .CLKS_PER_BIT(CPB),
    .STUFF_LIMIT (LIM)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .tx_data       (tx_data),
    .tx_last       (tx_last),
    .tx_data_valid (tx_data_valid),
    .tx_data_ready (tx_data_ready),
    .serial_out    (serial_out),
    .encoder_enable(encoder_enable),
    .clock_timer   (clock_timer),
    .eop_enable    (eop_enable),
    .tx_busy       (tx_busy),
    .tx_done       (tx_done),
    .tx_error      (tx_error)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Packet under test: npkt bytes, of which only the first navail are offered.
  logic [7:0] pkt [0:7];
  int         npkt;
  int         navail;

  // Expected bit periods
  logic e_ser [0:127];
  logic e_enc [0:127];
  logic e_eop [0:127];
  logic e_rdy [0:127];
  logic e_err [0:127];
  int   nper;

  // Observed event cycles, relative to the first SYNC cycle
  int rdy_cyc [$];
  int err_cyc;
  int done_cyc;
  int eop_cyc;

  function automatic void push_per(input logic s, input logic en, input logic eo);
    e_ser[nper] = s;
    e_enc[nper] = en;
    e_eop[nper] = eo;
    e_rdy[nper] = 1'b0;
    e_err[nper] = 1'b0;
    nper++;
  endfunction

  // Expand the packet into line bit periods from the protocol rules.
  function automatic void build_model();
    int  ones;
    bit  abort;
    logic [7:0] b;
    nper  = 0;
    ones  = 0;
    abort = 0;
    for (int i = 0; i < 8; i++) begin
      push_per((i == 7), 1'b1, 1'b0);
      ones = (i == 7) ? ones + 1 : 0;
    end
    if (navail > 0) e_rdy[nper-1] = 1'b1;
    else begin
      e_err[nper-1] = 1'b1;
      abort = 1;
    end
    for (int j = 0; j < npkt && !abort; j++) begin
      b = pkt[j];
      for (int i = 0; i < 8; i++) begin
        push_per(b[i], 1'b1, 1'b0);
        ones = b[i] ? ((ones < LIM) ? ones + 1 : ones) : 0;
        if (i == 7 && j != npkt - 1) begin
          if (j + 1 < navail) e_rdy[nper-1] = 1'b1;
          else begin
            e_err[nper-1] = 1'b1;
            abort = 1;
          end
        end
        if (!abort && ones == LIM) begin
          push_per(1'b0, 1'b1, 1'b0);
          ones = 0;
        end
      end
    end
    for (int k = 0; k < 2; k++) push_per(1'b0, 1'b0, 1'b1);
    push_per(1'b1, 1'b1, 1'b0);
  endfunction

  task automatic run_packet(input string name, input bit rand_valid);
    int idx;
    bit consume;
    int p;
    int pos;
    int total;
    bit lc;
    logic [7:0] obs;
    logic [7:0] exp;
    build_model();
    rdy_cyc.delete();
    err_cyc  = -1;
    done_cyc = -1;
    eop_cyc  = -1;
    @(negedge clk);
    tx_data       = pkt[0];
    tx_last       = (npkt == 1);
    tx_data_valid = 1'b1;
    idx     = 0;
    consume = 0;
    total   = nper * CPB + 1;
    for (int c = 0; c < total; c++) begin
      @(negedge clk);
      p   = c / CPB;
      pos = c % CPB;
      lc  = (pos == CPB - 1);
      if (consume) begin
        idx++;
        consume = 0;
        if (idx < navail) begin
          tx_data = pkt[idx];
          tx_last = (idx == npkt - 1);
        end
      end
      if (idx >= navail) tx_data_valid = 1'b0;
      else if (rand_valid && !lc) tx_data_valid = 1'($urandom_range(0, 1));
      else tx_data_valid = 1'b1;
      #1;
      if (p < nper)
        exp = {e_ser[p], e_enc[p], e_eop[p], lc, e_rdy[p] & lc, e_err[p] & lc,
               (p == nper - 1) & lc, 1'b1};
      else
        exp = 8'b1000_0000;
      obs = {serial_out, encoder_enable, eop_enable, clock_timer,
             tx_data_ready, tx_error, tx_done, tx_busy};
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL %s cycle %0d: {ser,enc,eop,ct,rdy,err,done,busy} got %b expected %b",
                 name, c, obs, exp);
      end
      if (tx_data_ready) begin
        consume = 1;
        rdy_cyc.push_back(c);
      end
      if (tx_error && err_cyc < 0) err_cyc = c;
      if (tx_done) done_cyc = c;
      if (eop_enable && eop_cyc < 0) eop_cyc = c;
    end
  endtask

  task automatic check_idle(input string name);
    logic [7:0] obs;
    obs = {serial_out, encoder_enable, eop_enable, clock_timer,
           tx_data_ready, tx_error, tx_done, tx_busy};
    n_checks++;
    if (obs !== 8'b1000_0000) begin
      n_fail++;
      $display("FAIL %s: outputs got %b expected 10000000", name, obs);
    end
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    tx_data       = '0;
    tx_last       = 1'b0;
    tx_data_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_idle("reset_values");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_idle("idle_after_release");
  endtask

  task automatic test_single_00();
    pkt[0] = 8'h00; npkt = 1; navail = 1;
    run_packet("single_00", 0);
    n_checks++;
    if (rdy_cyc.size() != 1 || rdy_cyc[0] != 63 || done_cyc != 151) begin
      n_fail++;
      $display("FAIL single_00_timing: ready count %0d first %0d done %0d, required 1 / 63 / 151",
               rdy_cyc.size(), (rdy_cyc.size() > 0) ? rdy_cyc[0] : -1, done_cyc);
    end
  endtask

  task automatic test_single_ff();
    pkt[0] = 8'hFF; npkt = 1; navail = 1;
    run_packet("single_ff", 0);
    n_checks++;
    if (done_cyc != 159) begin
      n_fail++;
      $display("FAIL single_ff_length: done at %0d, required 159", done_cyc);
    end
  endtask

  task automatic test_stuff_before_eop();
    pkt[0] = 8'hFC; npkt = 1; navail = 1;
    run_packet("stuff_fc", 0);
    n_checks++;
    if (eop_cyc != 136) begin
      n_fail++;
      $display("FAIL stuff_fc_eop: eop_enable first at %0d, required 136", eop_cyc);
    end
  endtask

  task automatic test_back_to_back();
    pkt[0] = 8'hA5; pkt[1] = 8'h5A; npkt = 2; navail = 2;
    run_packet("two_bytes", 0);
    n_checks++;
    if (rdy_cyc.size() != 2 || rdy_cyc[1] - rdy_cyc[0] != 64 || err_cyc != -1) begin
      n_fail++;
      $display("FAIL two_bytes_handshake: ready count %0d gap %0d error at %0d, required 2 / 64 / -1",
               rdy_cyc.size(), (rdy_cyc.size() == 2) ? rdy_cyc[1] - rdy_cyc[0] : -1, err_cyc);
    end
  endtask

  task automatic test_underrun();
    pkt[0] = 8'h3C; pkt[1] = 8'h00; npkt = 2; navail = 1;
    run_packet("underrun", 0);
    n_checks++;
    if (err_cyc != 127 || done_cyc != 151) begin
      n_fail++;
      $display("FAIL underrun_timing: error at %0d done at %0d, required 127 / 151", err_cyc, done_cyc);
    end
    // Stuff pending at the byte boundary is dropped by the underrun.
    pkt[0] = 8'hFC; pkt[1] = 8'h00; npkt = 2; navail = 1;
    run_packet("underrun_stuff", 0);
    n_checks++;
    if (err_cyc != 127 || eop_cyc != 128) begin
      n_fail++;
      $display("FAIL underrun_stuff_drop: error at %0d eop at %0d, required 127 / 128", err_cyc, eop_cyc);
    end
    pkt[0] = 8'hFC; pkt[1] = 8'h01; npkt = 2; navail = 2;
    run_packet("stuff_boundary", 1);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    tx_data       = 8'hFF;
    tx_last       = 1'b0;
    tx_data_valid = 1'b1;
    repeat (80) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_idle("reset_mid_data");
    @(negedge clk);
    tx_data_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    pkt[0] = 8'h81; npkt = 1; navail = 1;
    run_packet("after_reset", 0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 14; t++) begin
      npkt = $urandom_range(1, 4);
      for (int j = 0; j < npkt; j++) begin
        case ($urandom_range(0, 3))
          0:       pkt[j] = 8'hFF;
          1:       pkt[j] = 8'($urandom | $urandom);
          2:       pkt[j] = 8'hFC;
          default: pkt[j] = 8'($urandom);
        endcase
      end
      if (npkt > 1 && $urandom_range(0, 3) == 0) navail = $urandom_range(1, npkt - 1);
      else navail = npkt;
      run_packet($sformatf("random_%0d", t), 1);
    end
  endtask

  initial begin
    test_reset();
    test_single_00();
    test_single_ff();
    test_stuff_before_eop();
    test_back_to_back();
    test_underrun();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
